// File: rtl/lanes_deserializer_multi.sv
// Multi-lane serial-to-parallel deserializer with a per-frame width latch.
// Provides a single-word valid/ready holding register, a sticky overflow flag and a descrambler-reset pulse.
module lanes_deserializer_multi #(
  parameter int NUM_LANES = 2,
  parameter int MAX_W     = 132,
  parameter int W_GEN4    = 8,
  parameter int W_GEN3    = 132,
  parameter int W_GEN2    = 66
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 gen_speed,
  input  logic [NUM_LANES-1:0]       lane_rx_in,
  output logic [NUM_LANES*MAX_W-1:0] lane_rx_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       descr_rst,
  output logic                       overflow,
  output logic [7:0]                 cur_width
);

  localparam int LW = NUM_LANES * MAX_W;

  logic [LW-1:0] shift_p0;
  logic [LW-1:0] word_next;
  logic [7:0]    cnt;
  logic [7:0]    width_q;
  logic [7:0]    w_eff;
  logic          last;

  function automatic logic [7:0] width_sel(input logic [1:0] gs);
    case (gs)
      2'b01:   return 8'(W_GEN3);
      2'b10:   return 8'(W_GEN2);
      default: return 8'(W_GEN4);
    endcase
  endfunction

  // At frame start the width comes straight from gen_speed; afterwards from the latch.
  always_comb begin
    w_eff     = (cnt == 8'd0) ? width_sel(gen_speed) : width_q;
    last      = enable && (cnt == w_eff - 8'd1);
    descr_rst = enable && (cnt == w_eff - 8'd2);
    word_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      word_next[i*MAX_W +: MAX_W] =
        ((cnt == 8'd0) ? {MAX_W{1'b0}} : shift_p0[i*MAX_W +: MAX_W]) |
        ({{(MAX_W-1){1'b0}}, lane_rx_in[i]} << cnt);
    end
  end

  assign cur_width = width_q;

  // Stage p0 -> output: capture one bit per lane, hand off completed words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_p0    <= '0;
      cnt         <= 8'd0;
      lane_rx_out <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      width_q     <= 8'(W_GEN4);
    end else if (!enable) begin
      shift_p0    <= '0;
      cnt         <= 8'd0;
      lane_rx_out <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      shift_p0 <= word_next;
      if (cnt == 8'd0)
        width_q <= w_eff;
      if (last) begin
        cnt <= 8'd0;
        if (!out_valid || out_ready) begin
          lane_rx_out <= word_next;
          out_valid   <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else begin
        cnt <= cnt + 8'd1;
        if (out_valid && out_ready)
          out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lanes_deserializer_multi.md
Name: lanes_deserializer_multi

Overview:
Parametrised successor of the two-lane deserializer. Converts NUM_LANES serial bitstreams into lane-aligned parallel words whose width is selected by gen_speed. Adds a valid/ready output handshake with single-word holding, a sticky overflow flag, a mode latch and a frame-boundary descrambler-reset pulse. Sits between the lane receivers and the per-lane descrambler/decoder stage.

Parameters:
NUM_LANES, 2, number of serial lanes deserialized in lockstep
MAX_W, 132, width of each lane's output slice in bits
W_GEN4, 8, word width for gen_speed 2'b00 and 2'b11
W_GEN3, 132, word width for gen_speed 2'b01
W_GEN2, 66, word width for gen_speed 2'b10 (all widths >= 2 and <= MAX_W)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
enable  in  1  deserialization enable; low = flush and idle
gen_speed  in  2  word-width select, sampled only at frame start
lane_rx_in  in  NUM_LANES  serial bit per lane, bit i = lane i
lane_rx_out  out  NUM_LANES*MAX_W  parallel words; lane i at [i*MAX_W +: MAX_W]
out_valid  out  1  lane_rx_out holds an unconsumed word
out_ready  in  1  consumer accepts word when out_valid && out_ready
descr_rst  out  1  one-cycle pulse ahead of each frame boundary
overflow  out  1  sticky: a completed word was dropped
cur_width  out  8  active word width W (debug/status)

Behaviour:
- Reset (rst high, async): shift registers, bit counter, lane_rx_out, out_valid, overflow = 0; mode latch = GEN4 (cur_width = W_GEN4).
- enable low (synchronous): same clearing as reset except the mode latch holds its value. descr_rst = 0.
- Mode latch: on any enabled cycle with counter == 0, W is loaded from gen_speed (00/11 -> W_GEN4, 01 -> W_GEN3, 10 -> W_GEN2) and held until the frame completes. Changes to gen_speed mid-frame are ignored.
- Shifting: each enabled cycle, one bit per lane is captured. The k-th captured bit of a frame (k = 0..W-1) lands at word bit k, so the first bit received is the LSB. Bits [MAX_W-1:W] of each lane slice are 0.
- Counter: runs 0..W-1 and wraps to 0 after W-1. No idle cycles between frames.
- Completion: at the clock edge where counter == W-1, the full word (including that cycle's bit) is the completed word.
  - If out_valid == 0, or out_ready == 1 in that cycle: the word is loaded into lane_rx_out and out_valid = 1 from the next cycle. Latency is 1 cycle after the last bit is sampled.
  - If out_valid == 1 and out_ready == 0: the word is dropped, lane_rx_out is unchanged, and overflow is set. overflow is cleared only by reset or by enable low.
- Consumption: out_valid && out_ready with no simultaneous completion -> out_valid = 0 next cycle; lane_rx_out holds its old value.
- descr_rst: combinational, high when enable && counter == W-2 with W the latched width. For the first frame after enable, W comes from the current gen_speed.
- All lanes share the counter and mode; lanes are never skewed relative to each other.
- enable falling mid-frame: the partial word is discarded. The next enable starts at counter 0 with a fresh mode sample.

Test Plan:
- Reset/idle: rst high mid-frame -> all outputs 0, cur_width = 8. enable=0 for 5 cycles -> out_valid and descr_rst stay 0.
- GEN4, 2 lanes, out_ready=1: lane0 stream 1,0,1,1,0,0,1,0 and lane1 all-ones -> after 8 bits, lane0 slice = 0x4D, lane1 slice = 0xFF, upper 124 bits 0. out_valid rises 1 cycle after bit 8. descr_rst is high on cycles 7, 15, 23 (counter = 6).
- GEN2 width: gen_speed=10, random 66-bit word per lane -> slice[65:0] matches the word, [131:66] = 0. A new word arrives every 66 cycles, and descr_rst is high at counter 64.
- Mode latch: switch gen_speed 00->01 at counter 3 -> the current frame completes at 8 bits; the next frame is 132 bits and cur_width = 132.
- Backpressure: out_ready=0 across two completions -> first word held, overflow=1 after the second completion. Then out_ready=1 -> out_valid drops next cycle, and overflow stays 1 until enable low.
- Simultaneous consume/complete: out_ready=1 on a completion cycle with out_valid=1 -> the new word replaces the old one, out_valid stays 1 and overflow stays 0. Also enable low mid-frame, then re-enable -> the first word is fully new, with no stale bits.
